// File: rtl/sym_act_scheduler.sv
// Round-robin front end that shares one symmetry-aware activation core among NREQ
// requesters: clamp/issue, sideband delay line, sign reconstruction and credit-guarded result FIFO.
module sym_act_scheduler #(
  parameter int M          = 4,
  parameter int N          = 8,
  parameter int NREQ       = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TAGW       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*(M+N)-1:0]  req_data,
  input  logic [NREQ*2-1:0]      req_mode,
  output logic [NREQ-1:0]        req_ready,
  output logic                   iss_valid,
  output logic [M+N-1:0]         iss_x,
  input  logic [M+N-1:0]         core_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [M+N-1:0]         res_data,
  output logic [TAGW-1:0]        res_tag,
  output logic                   busy
);

  localparam int W   = M + N;
  localparam int SBW = TAGW + 3;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [W-1:0] ONE_N   = {{(W-1){1'b0}}, 1'b1} << N;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] CLAMPED  = {1'b1, {(W-2){1'b0}}, 1'b1};

  logic [TAGW-1:0]       ptr_reg;
  logic [LAT:0]          vld_line_reg;
  logic [LAT:0][SBW-1:0] sb_line_reg;
  logic [W-1:0]          iss_x_reg;
  logic [CW-1:0]         inflight_reg;
  logic [CW-1:0]         fifo_count_reg;
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [W+TAGW-1:0]     mem [FIFO_DEPTH];

  logic                  grant_found;
  logic [TAGW-1:0]       grant_idx;
  int                    cand;
  logic [CW:0]           outstanding;
  logic                  credit_ok;
  logic                  accept;
  logic [W-1:0]          op_sel;
  logic [1:0]            mode_sel;
  logic [W-1:0]          op_clamped;
  logic                  wr_en;
  logic                  pop;
  logic                  ret_sign;
  logic [1:0]            ret_mode;
  logic [TAGW-1:0]       ret_tag;
  logic [W-1:0]          post_y;
  logic [W+TAGW-1:0]     head;

  // First valid requester at or after the pointer, wrapping upward.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_reg) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = TAGW'(cand);
      end
    end
  end

  // Credit is taken from registered counts only; a pop this cycle frees nothing until next cycle.
  assign outstanding = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);
  assign accept      = grant_found & credit_ok & ~rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == TAGW'(gi));
    end
  endgenerate

  assign op_sel     = req_data[int'(grant_idx)*W +: W];
  assign mode_sel   = req_mode[int'(grant_idx)*2 +: 2];
  assign op_clamped = (op_sel == MOST_NEG) ? CLAMPED : op_sel;

  assign wr_en    = vld_line_reg[LAT];
  assign ret_sign = sb_line_reg[LAT][TAGW+2];
  assign ret_mode = sb_line_reg[LAT][TAGW+1:TAGW];
  assign ret_tag  = sb_line_reg[LAT][TAGW-1:0];

  always_comb begin
    post_y = core_y;
    case (ret_mode)
      2'd1:    post_y = core_y;
      2'd2:    post_y = ret_sign ? (ONE_N - core_y) : core_y;
      default: post_y = ret_sign ? (~core_y + 1'b1) : core_y;
    endcase
  end

  assign res_valid = (fifo_count_reg != '0);
  assign pop       = res_valid & res_ready;
  assign head      = mem[rd_ptr_reg];
  assign res_data  = res_valid ? head[W-1:0] : '0;
  assign res_tag   = res_valid ? head[W+TAGW-1:W] : '0;
  assign iss_valid = vld_line_reg[0];
  assign iss_x     = iss_x_reg;
  assign busy      = (inflight_reg != '0) | res_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg        <= '0;
      vld_line_reg   <= '0;
      sb_line_reg    <= '0;
      iss_x_reg      <= '0;
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      // Stage 0 is the issue register; stage LAT lines up with core_y.
      vld_line_reg          <= {vld_line_reg[LAT-1:0], accept};
      sb_line_reg[LAT:1]    <= sb_line_reg[LAT-1:0];
      sb_line_reg[0]        <= {op_sel[W-1], mode_sel, grant_idx};
      if (accept) begin
        iss_x_reg <= op_clamped;
        ptr_reg   <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + TAGW'(1);
      end
      case ({accept, wr_en})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      case ({wr_en, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {ret_tag, post_y};
  end

endmodule

// File: tb/tb_sym_act_scheduler.sv
// Randomized bench for sym_act_scheduler: a queue-based model predicts grants, issue,
// result timing/values and credit stalls; core_y is supplied from a per-cycle schedule.
module tb_sym_act_scheduler;

  localparam int W     = 12;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*2-1:0] req_mode;
  logic [NREQ-1:0]   req_ready;
  logic              iss_valid;
  logic [W-1:0]      iss_x;
  logic [W-1:0]      core_y;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [1:0]        res_tag;
  logic              busy;

  sym_act_scheduler #(.M(4), .N(8), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(DEPTH), .TAGW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_mode(req_mode),
    .req_ready(req_ready), .iss_valid(iss_valid), .iss_x(iss_x), .core_y(core_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   tag;
    int           rdy;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] ysched[int];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           ptr_m = 0;
  int           pv = 0;
  int           pr = 100;
  bit           only0 = 1'b0;
  bit           exp_iss_v = 1'b0;
  logic [W-1:0] exp_iss_x = '0;
  bit           dir_fire = 1'b0;
  logic [W-1:0] dir_x, dir_y;
  logic [1:0]   dir_m;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Symmetry reconstruction from the rules: odd negates, complement reflects about 1.0.
  function automatic logic [W-1:0] post_ref(input logic [W-1:0] x, input logic [1:0] m,
                                            input logic [W-1:0] y);
    int r;
    if (m == 2'd1 || !x[W-1]) r = int'(y);
    else if (m == 2'd2)       r = 256 - int'(y);
    else                      r = -int'(y);
    return r[W-1:0];
  endfunction

  task automatic cycle(input bit do_rst);
    bit           exp_rv;
    int           g;
    int           idx;
    logic [3:0]   exp_rr;
    logic [W-1:0] x, y;
    logic [1:0]   m;
    ent_t         e;
    @(posedge clk);
    cyc++;
    #1;
    check_eq("iss_valid", 32'(iss_valid), 32'(exp_iss_v));
    if (exp_iss_v) check_eq("iss_x", 32'(iss_x), 32'(exp_iss_x));
    exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
    check_eq("res_valid", 32'(res_valid), 32'(exp_rv));
    if (exp_rv) begin
      check_eq("res_data", 32'(res_data), 32'(q[0].data));
      check_eq("res_tag", 32'(res_tag), 32'(q[0].tag));
    end
    check_eq("busy", 32'(busy), 32'(q.size() != 0));

    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = ($urandom_range(99) < pv);
      req_data[i*W +: W]  = W'($urandom);
      req_mode[i*2 +: 2]  = 2'($urandom);
    end
    if (only0) req_valid = 4'b0001;
    if (dir_fire) begin
      req_valid     = 4'b0001;
      req_data[W-1:0] = dir_x;
      req_mode[1:0] = dir_m;
    end
    res_ready = ($urandom_range(99) < pr);
    core_y = ysched.exists(cyc) ? ysched[cyc] : W'($urandom);

    if (do_rst) begin
      rst = 1'b1;
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'h0);
      check_eq("rst_iss_valid", 32'(iss_valid), 32'h0);
      check_eq("rst_iss_x", 32'(iss_x), 32'h0);
      check_eq("rst_res_valid", 32'(res_valid), 32'h0);
      check_eq("rst_res_data", 32'(res_data), 32'h0);
      check_eq("rst_res_tag", 32'(res_tag), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      $display("reset with %0d ops outstanding", q.size());
      q.delete();
      ysched.delete();
      ptr_m     = 0;
      exp_iss_v = 1'b0;
      dir_fire  = 1'b0;
      return;
    end

    #1;
    g = -1;
    if (q.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rr = (g >= 0) ? 4'(1 << g) : 4'h0;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rr));
    exp_iss_v = (g >= 0);

    if (exp_rv && res_ready) begin
      $display("pop  tag=%0d data=%03h cycle=%0d", q[0].tag, q[0].data, cyc);
      void'(q.pop_front());
    end
    if (g >= 0) begin
      x = req_data[g*W +: W];
      m = req_mode[g*2 +: 2];
      y = dir_fire ? dir_y : W'($urandom);
      exp_iss_x = (x == 12'h800) ? 12'h801 : x;
      ysched[cyc + 1 + LAT] = y;
      e.data = post_ref(x, m, y);
      e.tag  = 2'(g);
      e.rdy  = cyc + LAT + 2;
      q.push_back(e);
      ptr_m = (g + 1) % NREQ;
    end
    dir_fire = 1'b0;
  endtask

  task automatic run(input int n, input int pv_i, input int pr_i, input bit only0_i);
    pv = pv_i;
    pr = pr_i;
    only0 = only0_i;
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [1:0] m, input logic [W-1:0] y);
    dir_x = x;
    dir_m = m;
    dir_y = y;
    dir_fire = 1'b1;
    pv = 0;
    pr = 100;
    only0 = 1'b0;
    cycle(1'b0);
    run(7, 0, 100, 1'b0);
  endtask

  logic [W-1:0] dxs [8] = '{12'hE80, 12'hFC0, 12'h040, 12'hF00, 12'h800, 12'h000, 12'h800, 12'h7FF};
  logic [1:0]   dms [8] = '{2'd0,    2'd2,    2'd2,    2'd1,    2'd0,    2'd0,    2'd2,    2'd3};
  logic [W-1:0] dys [8] = '{12'h0C0, 12'h0A0, 12'h0A0, 12'h123, 12'h7FF, 12'h055, 12'h300, 12'h7FF};

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_data = '0;
    req_mode = '0;
    res_ready = 1'b0;
    core_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_req_ready", 32'(req_ready), 32'h0);
    check_eq("init_iss_valid", 32'(iss_valid), 32'h0);
    check_eq("init_res_valid", 32'(res_valid), 32'h0);
    check_eq("init_res_data", 32'(res_data), 32'h0);
    check_eq("init_busy", 32'(busy), 32'h0);
    req_valid = '0;

    for (int i = 0; i < 8; i++) directed(dxs[i], dms[i], dys[i]);

    run(40, 100, 100, 1'b0);   // every requester valid, consumer always ready
    run(300, 60, 70, 1'b0);
    run(15, 0, 100, 1'b0);
    run(20, 100, 0, 1'b1);     // stall: credit must cap acceptance at the FIFO depth
    run(1, 100, 100, 1'b1);
    run(6, 100, 0, 1'b1);
    run(20, 0, 100, 1'b0);
    run(12, 90, 25, 1'b0);
    cycle(1'b1);
    run(200, 70, 60, 1'b0);
    run(25, 0, 100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
